// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: EXEC/MEM stepping, memory-latency stall, Start/Ack handshake,
// and saturating retired-instruction and cycle counters.
module ctrl_fsm #(
  parameter int unsigned    IW      = 9,
  parameter int unsigned    OPW     = 4,
  parameter int unsigned    MEM_LAT = 1,
  parameter int unsigned    CW      = 16,
  parameter logic [OPW-1:0] OP_LDI  = 4'b0000,
  parameter logic [OPW-1:0] OP_LDR  = 4'b0001,
  parameter logic [OPW-1:0] OP_STR  = 4'b0110
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  output logic          PcEn,
  output logic          PcRst,
  output logic          RegWrEn,
  output logic [1:0]    RegLoadType,
  output logic          StoreInst,
  output logic          Ack,
  output logic          Busy,
  output logic [CW-1:0] InstCnt,
  output logic [CW-1:0] CycleCnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StMem  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] LdInit = 3'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);

  logic [1:0]     state_q, state_d;
  logic [2:0]     ldcnt_q, ldcnt_d;
  logic [CW-1:0]  inst_q, inst_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [OPW-1:0] opcode;
  logic           is_halt, is_wr_op;
  logic           pcen, pcrst, regwr, store;
  logic [1:0]     ltype;

  assign opcode  = Instruction[IW-1 -: OPW];
  assign is_halt = &Instruction;
  // Writing opcodes are the first six codes of each half of the opcode space.
  assign is_wr_op = (opcode[OPW-2:0] <= (OPW-1)'(5));

  always_comb begin
    state_d = state_q;
    ldcnt_d = ldcnt_q;
    pcen    = 1'b0;
    pcrst   = 1'b0;
    regwr   = 1'b0;
    store   = 1'b0;
    ltype   = 2'b10;
    case (state_q)
      StIdle, StDone: begin
        // Gate with reset so a held Start cannot pulse PcRst while in reset.
        if (Start && Reset_n) begin
          pcrst   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (opcode == OP_LDI)      ltype = 2'b00;
        else if (opcode == OP_LDR) ltype = 2'b01;
        if (is_halt) begin
          state_d = StDone;
        end else if (opcode == OP_LDR) begin
          if (MEM_LAT == 0) begin
            regwr = 1'b1;
            pcen  = 1'b1;
          end else begin
            state_d = StMem;
            ldcnt_d = LdInit;
          end
        end else if (opcode == OP_STR) begin
          store = 1'b1;
          pcen  = 1'b1;
        end else if (is_wr_op) begin
          regwr = 1'b1;
          pcen  = 1'b1;
        end else begin
          pcen = 1'b1;
        end
      end
      StMem: begin
        ltype = 2'b01;
        if (ldcnt_q == 3'd0) begin
          regwr   = 1'b1;
          pcen    = 1'b1;
          state_d = StExec;
        end else begin
          ldcnt_d = ldcnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_d = inst_q;
    cyc_d  = cyc_q;
    if (pcrst) begin
      inst_d = '0;
      cyc_d  = '0;
    end else begin
      if (pcen && (inst_q != '1)) inst_d = inst_q + CW'(1);
      if (((state_q == StExec) || (state_q == StMem)) && (cyc_q != '1)) cyc_d = cyc_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      ldcnt_q <= 3'd0;
      inst_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ldcnt_q <= ldcnt_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
    end
  end

  assign PcEn        = pcen;
  assign PcRst       = pcrst;
  assign RegWrEn     = regwr;
  assign RegLoadType = ltype;
  assign StoreInst   = store;
  assign Ack         = (state_q == StDone);
  assign Busy        = (state_q == StExec) || (state_q == StMem);
  assign InstCnt     = inst_q;
  assign CycleCnt    = cyc_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Table-driven bench for ctrl_fsm: four instances (MEM_LAT 0/1/3, and CW=3) share clock and reset.
module tb_ctrl_fsm;

  typedef struct packed {
    logic        pcen;
    logic        pcrst;
    logic        regwr;
    logic [1:0]  lt;
    logic        store;
    logic        ack;
    logic        busy;
    logic [15:0] inst;
    logic [15:0] cyc;
  } outs_t;

  typedef struct {
    int         sel;
    logic       start;
    logic [8:0] instr;
    outs_t      exp;
  } vec_t;

  logic       clk, rst_n;
  logic [3:0] start_v;
  logic [8:0] instr_v [4];
  logic [3:0] pcen, pcrst, regwr, store, ack, busy;
  logic [1:0] lt [4];
  logic [15:0] inst [4];
  logic [15:0] cyc [4];
  logic [2:0]  inst_s, cyc_s;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t  tbl [$];
  outs_t sb [$];

  always #5 clk = ~clk;

  ctrl_fsm #(.MEM_LAT(0)) u_lat0 (
    .Clk(clk), .Reset_n(rst_n), .Start(start_v[0]), .Instruction(instr_v[0]),
    .PcEn(pcen[0]), .PcRst(pcrst[0]), .RegWrEn(regwr[0]), .RegLoadType(lt[0]),
    .StoreInst(store[0]), .Ack(ack[0]), .Busy(busy[0]), .InstCnt(inst[0]), .CycleCnt(cyc[0])
  );
  ctrl_fsm #(.MEM_LAT(1)) u_lat1 (
    .Clk(clk), .Reset_n(rst_n), .Start(start_v[1]), .Instruction(instr_v[1]),
    .PcEn(pcen[1]), .PcRst(pcrst[1]), .RegWrEn(regwr[1]), .RegLoadType(lt[1]),
    .StoreInst(store[1]), .Ack(ack[1]), .Busy(busy[1]), .InstCnt(inst[1]), .CycleCnt(cyc[1])
  );
  ctrl_fsm #(.MEM_LAT(3)) u_lat3 (
    .Clk(clk), .Reset_n(rst_n), .Start(start_v[2]), .Instruction(instr_v[2]),
    .PcEn(pcen[2]), .PcRst(pcrst[2]), .RegWrEn(regwr[2]), .RegLoadType(lt[2]),
    .StoreInst(store[2]), .Ack(ack[2]), .Busy(busy[2]), .InstCnt(inst[2]), .CycleCnt(cyc[2])
  );
  ctrl_fsm #(.MEM_LAT(1), .CW(3)) u_sat (
    .Clk(clk), .Reset_n(rst_n), .Start(start_v[3]), .Instruction(instr_v[3]),
    .PcEn(pcen[3]), .PcRst(pcrst[3]), .RegWrEn(regwr[3]), .RegLoadType(lt[3]),
    .StoreInst(store[3]), .Ack(ack[3]), .Busy(busy[3]), .InstCnt(inst_s), .CycleCnt(cyc_s)
  );
  assign inst[3] = {13'd0, inst_s};
  assign cyc[3]  = {13'd0, cyc_s};

  function automatic outs_t e(input logic pe, input logic pr, input logic rw, input logic [1:0] t,
                              input logic st, input logic ak, input logic by,
                              input int ic, input int cc);
    outs_t o;
    o.pcen = pe; o.pcrst = pr; o.regwr = rw; o.lt = t; o.store = st;
    o.ack = ak; o.busy = by; o.inst = 16'(ic); o.cyc = 16'(cc);
    return o;
  endfunction

  function automatic outs_t get_act(input int s);
    outs_t o;
    o.pcen = pcen[s]; o.pcrst = pcrst[s]; o.regwr = regwr[s]; o.lt = lt[s];
    o.store = store[s]; o.ack = ack[s]; o.busy = busy[s]; o.inst = inst[s]; o.cyc = cyc[s];
    return o;
  endfunction

  task automatic add(input int s, input logic st, input logic [8:0] ins, input outs_t x);
    vec_t v;
    v.sel = s; v.start = st; v.instr = ins; v.exp = x;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input outs_t a, input outs_t x);
    n_checks++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got pcen=%b pcrst=%b regwr=%b lt=%b st=%b ack=%b busy=%b inst=%0d cyc=%0d; want pcen=%b pcrst=%b regwr=%b lt=%b st=%b ack=%b busy=%b inst=%0d cyc=%0d",
               name, a.pcen, a.pcrst, a.regwr, a.lt, a.store, a.ack, a.busy, a.inst, a.cyc,
               x.pcen, x.pcrst, x.regwr, x.lt, x.store, x.ack, x.busy, x.inst, x.cyc);
    end
  endtask

  outs_t idle0;

  initial begin
    idle0 = e(0, 0, 0, 2'b10, 0, 0, 0, 0, 0);

    // MEM_LAT=1: LDR / STR / halt, restart, mixed opcodes, Start while busy
    add(1, 0, 9'h000, idle0);
    add(1, 1, 9'h020, e(0, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    add(1, 0, 9'h020, e(0, 0, 0, 2'b01, 0, 0, 1, 0, 0));
    add(1, 0, 9'h020, e(1, 0, 1, 2'b01, 0, 0, 1, 0, 1));
    add(1, 0, 9'h0C0, e(1, 0, 0, 2'b10, 1, 0, 1, 1, 2));
    add(1, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 0, 1, 2, 3));
    add(1, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 1, 0, 2, 4));
    add(1, 1, 9'h000, e(0, 1, 0, 2'b10, 0, 1, 0, 2, 4));
    add(1, 0, 9'h000, e(1, 0, 1, 2'b00, 0, 0, 1, 0, 0));
    add(1, 0, 9'h0E0, e(1, 0, 0, 2'b10, 0, 0, 1, 1, 1));
    add(1, 0, 9'h100, e(1, 0, 1, 2'b10, 0, 0, 1, 2, 2));
    add(1, 0, 9'h1C0, e(1, 0, 0, 2'b10, 0, 0, 1, 3, 3));
    add(1, 1, 9'h0A0, e(1, 0, 1, 2'b10, 0, 0, 1, 4, 4));
    add(1, 0, 9'h1FE, e(1, 0, 0, 2'b10, 0, 0, 1, 5, 5));
    add(1, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 0, 1, 6, 6));
    add(1, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 1, 0, 6, 7));
    // MEM_LAT=0: LDR completes in EXEC
    add(0, 1, 9'h020, e(0, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    add(0, 0, 9'h020, e(1, 0, 1, 2'b01, 0, 0, 1, 0, 0));
    add(0, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 0, 1, 1, 1));
    add(0, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 1, 0, 1, 2));
    // MEM_LAT=3: three stall cycles
    add(2, 1, 9'h020, e(0, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    add(2, 0, 9'h020, e(0, 0, 0, 2'b01, 0, 0, 1, 0, 0));
    add(2, 0, 9'h020, e(0, 0, 0, 2'b01, 0, 0, 1, 0, 1));
    add(2, 0, 9'h020, e(0, 0, 0, 2'b01, 0, 0, 1, 0, 2));
    add(2, 0, 9'h020, e(1, 0, 1, 2'b01, 0, 0, 1, 0, 3));
    add(2, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 0, 1, 1, 4));
    add(2, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 1, 0, 1, 5));
    // CW=3: counters saturate at 7
    add(3, 1, 9'h000, e(0, 1, 0, 2'b10, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      add(3, 0, 9'h000, e(1, 0, 1, 2'b00, 0, 0, 1, (k > 7) ? 7 : k, (k > 7) ? 7 : k));
    add(3, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 0, 1, 7, 7));
    add(3, 0, 9'h1FF, e(0, 0, 0, 2'b10, 0, 1, 0, 7, 7));

    // Reset held across edges with Start high must stay idle
    clk = 1'b0;
    rst_n = 1'b0;
    start_v = 4'hF;
    for (int i = 0; i < 4; i++) instr_v[i] = 9'h020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold_lat1", get_act(1), idle0);
    check("reset_hold_lat3", get_act(2), idle0);
    start_v = 4'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", get_act(1), idle0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      start_v = 4'h0;
      start_v[tbl[i].sel] = tbl[i].start;
      instr_v[tbl[i].sel] = tbl[i].instr;
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      check($sformatf("row%0d", i), get_act(tbl[i].sel), sb.pop_front());
    end

    // Reset during the second MEM cycle of a MEM_LAT=3 load
    @(posedge clk);
    #1;
    start_v = 4'b0100;
    instr_v[2] = 9'h020;
    @(negedge clk);
    check("mm_start", get_act(2), e(0, 1, 0, 2'b10, 0, 1, 0, 1, 5));
    @(posedge clk);
    #1;
    start_v = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mm_in_mem", get_act(2), e(0, 0, 0, 2'b01, 0, 0, 1, 0, 2));
    rst_n = 1'b0;
    #1;
    check("mm_async", get_act(2), idle0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("mm_idle%0d", i), get_act(2), idle0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
